dmem_arbiter: RTL and testbench

- Owns the 256 x 64-bit data RAM and shares it between two requesters.
  - Port A is the CPU load/store path.
  - Port B is the debug/loader path.
- Performs exactly one access per clock.
- After reset, or on a clear request, it runs a zero-fill sweep of the whole RAM.
- Mirrors every write to the IO address onto an io_write/io_data strobe.

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data RAM: zero-fill sweep after reset/clear,
// round-robin grants between CPU (A) and debug (B), and a write mirror for the IO address.
module dmem_arbiter #(
    parameter int                DATA_W  = 64,
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] IO_ADDR = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              init_done,
    output logic              io_write,
    output logic [DATA_W-1:0] io_data,
    output logic [15:0]       conflict_cnt,
    output logic              dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    // Handshake: a requester raises x_req with stable we/addr/wdata and holds it until x_gnt
    // is seen high in the same cycle; the access happens on that rising edge. Dropping
    // x_req before x_gnt withdraws it. Reads return x_rdata with a one-cycle x_rvalid pulse
    // on the following edge; there is no back-pressure on the read return.
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic                prio_q, prio_d;          // 0 = A has priority, 1 = B
    logic                init_done_q, init_done_d;
    logic                a_rvalid_q, a_rvalid_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                io_write_q, io_write_d;
    logic [DATA_W-1:0]   io_data_q, io_data_d;
    logic [15:0]         conflict_cnt_q, conflict_cnt_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                run;
    logic                a_gnt_c, b_gnt_c;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // A clear arriving in RUN suppresses the grant of that same cycle.
    always_comb begin
        run     = (state_q == ST_RUN);
        a_gnt_c = run & ~clr & a_req & (~b_req | ~prio_q);
        b_gnt_c = run & ~clr & b_req & (~a_req | prio_q);

        acc_we    = (a_gnt_c & a_we) | (b_gnt_c & b_we);
        acc_addr  = a_gnt_c ? a_addr  : b_addr;
        acc_wdata = a_gnt_c ? a_wdata : b_wdata;

        mem_we    = ~run | acc_we;
        mem_waddr = run ? acc_addr  : sweep_cnt_q;
        mem_wdata = run ? acc_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        prio_d      = prio_q;

        a_rvalid_d = a_gnt_c & ~a_we;
        b_rvalid_d = b_gnt_c & ~b_we;
        a_rdata_d  = a_rvalid_d ? mem_q[a_addr] : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_q[b_addr] : b_rdata_q;

        io_write_d = acc_we & (acc_addr == IO_ADDR);
        io_data_d  = io_write_d ? acc_wdata : '0;

        conflict_cnt_d = conflict_cnt_q;
        if (run && a_req && b_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end

        if (a_gnt_c) begin
            prio_d = 1'b1;
        end else if (b_gnt_c) begin
            prio_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                sweep_cnt_d = sweep_cnt_q + ADDR_W'(1);
                if (clr) begin
                    sweep_cnt_d = '0;
                end else if (sweep_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_d     = ST_INIT;
                    sweep_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ST_INIT;
                sweep_cnt_d = '0;
            end
        endcase

        init_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_INIT;
            sweep_cnt_q    <= '0;
            prio_q         <= 1'b0;
            init_done_q    <= 1'b0;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
            io_write_q     <= 1'b0;
            io_data_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            sweep_cnt_q    <= sweep_cnt_d;
            prio_q         <= prio_d;
            init_done_q    <= init_done_d;
            a_rvalid_q     <= a_rvalid_d;
            b_rvalid_q     <= b_rvalid_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
            io_write_q     <= io_write_d;
            io_data_q      <= io_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign a_gnt        = a_gnt_c;
    assign b_gnt        = b_gnt_c;
    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign init_done    = init_done_q;
    assign io_write     = io_write_q;
    assign io_data      = io_data_q;
    assign conflict_cnt = conflict_cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: sweep timing, grants, read latency, IO mirror, clear and reset.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [7:0]  a_addr = '0;
    logic [63:0] a_wdata = '0;
    logic        a_gnt, a_rvalid;
    logic [63:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [7:0]  b_addr = '0;
    logic [63:0] b_wdata = '0;
    logic        b_gnt, b_rvalid;
    logic [63:0] b_rdata;
    logic        init_done, io_write;
    logic [63:0] io_data;
    logic [15:0] conflict_cnt;
    logic        dbg_state;

    int errors = 0;
    int checks = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst), .clr(clr),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .init_done(init_done), .io_write(io_write), .io_data(io_data),
        .conflict_cnt(conflict_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        int  cyc;
        bit  seen_gnt;
        rst = 1'b1; a_req = 1'b1; a_we = 1'b0; a_addr = 8'h33;
        #1;
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %0b want 0", init_done); end
        checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt: got %0b want 0", a_gnt); end
        checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %0b/%0b want 0/0", a_rvalid, b_rvalid); end
        checks++; if (io_write !== 1'b0 || io_data !== 64'h0) begin errors++; $display("FAIL rst_io: got %0b/%h want 0/0", io_write, io_data); end
        checks++; if (conflict_cnt !== 16'h0) begin errors++; $display("FAIL rst_conflict: got %0d want 0", conflict_cnt); end
        @(negedge clk); rst = 1'b0;
        cyc = 0; seen_gnt = 1'b0;
        while (init_done !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1; cyc++;
            if (init_done !== 1'b1 && a_gnt === 1'b1) seen_gnt = 1'b1;
        end
        a_req = 1'b0;
        checks++; if (cyc != 256) begin errors++; $display("FAIL sweep_len: got %0d want 256", cyc); end
        checks++; if (seen_gnt) begin errors++; $display("FAIL init_gnt: got grant during sweep want none"); end
    endtask

    task automatic test_init_reads();
        logic [7:0] addr;
        for (int i = 0; i < 2; i++) begin
            addr = (i == 0) ? 8'h10 : 8'hFF;
            @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = addr; #1;
            checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL init_rd_gnt[%h]: got %0b want 1", addr, a_gnt); end
            @(posedge clk); #1;
            checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'h0) begin errors++; $display("FAIL init_rd[%h]: got v=%0b d=%h want v=1 d=0", addr, a_rvalid, a_rdata); end
            checks++; if (io_write !== 1'b0) begin errors++; $display("FAIL init_rd_io[%h]: got %0b want 0", addr, io_write); end
            @(negedge clk); a_req = 1'b0;
            @(posedge clk); #1;
            checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL init_rd_pulse[%h]: got %0b want 0", addr, a_rvalid); end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk); a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 64'hDEAD_BEEF; #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL wr_a_gnt: got %0b want 1", a_gnt); end
        @(negedge clk); a_req = 1'b0; a_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h05; #1;
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %0b want 0", a_rvalid); end
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL rd_b_gnt: got %0b want 1", b_gnt); end
        @(posedge clk); #1;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL raw_b: got v=%0b d=%h want v=1 d=deadbeef", b_rvalid, b_rdata); end
        @(negedge clk); b_req = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_a;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_a = (i % 2 == 0);
            checks++; if (a_gnt !== exp_a || b_gnt !== ~exp_a) begin errors++; $display("FAIL alt[%0d]: got a=%0b b=%0b want a=%0b b=%0b", i, a_gnt, b_gnt, exp_a, ~exp_a); end
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0; #1;
        checks++; if (conflict_cnt !== 16'd6) begin errors++; $display("FAIL conflict_cnt: got %0d want 6", conflict_cnt); end
    endtask

    task automatic test_io();
        @(negedge clk); b_req = 1'b1; b_we = 1'b1; b_addr = 8'hFF; b_wdata = 64'h1234; #1;
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL io_b_gnt: got %0b want 1", b_gnt); end
        @(posedge clk); #1;
        checks++; if (io_write !== 1'b1 || io_data !== 64'h1234) begin errors++; $display("FAIL io_pulse: got %0b/%h want 1/1234", io_write, io_data); end
        @(negedge clk); b_req = 1'b0; b_we = 1'b0;
        @(posedge clk); #1;
        checks++; if (io_write !== 1'b0 || io_data !== 64'h0) begin errors++; $display("FAIL io_one_cycle: got %0b/%h want 0/0", io_write, io_data); end
        @(negedge clk); a_req = 1'b1; a_we = 1'b1; a_addr = 8'hFE; a_wdata = 64'h5555;
        @(posedge clk); #1;
        checks++; if (io_write !== 1'b0 || io_data !== 64'h0) begin errors++; $display("FAIL io_fe: got %0b/%h want 0/0", io_write, io_data); end
        @(negedge clk); a_req = 1'b0; a_we = 1'b0;
    endtask

    task automatic test_clr();
        int cyc;
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05; #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL clr_rd_gnt: got %0b want 1", a_gnt); end
        @(negedge clk); a_req = 1'b0; clr = 1'b1; b_req = 1'b1; b_we = 1'b0; b_addr = 8'h05; #1;
        checks++; if (b_gnt !== 1'b0 || a_gnt !== 1'b0) begin errors++; $display("FAIL clr_gnt_forced: got a=%0b b=%0b want 0/0", a_gnt, b_gnt); end
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL clr_rvalid: got v=%0b d=%h want v=1 d=deadbeef", a_rvalid, a_rdata); end
        @(posedge clk); #1;
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL clr_init_done: got %0b want 0", init_done); end
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL clr_b_rvalid: got %0b want 0", b_rvalid); end
        @(negedge clk); clr = 1'b0; b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05;
        cyc = 0; #1;
        while (a_gnt !== 1'b1 && cyc < 400) begin
            @(negedge clk); #1; cyc++;
        end
        checks++; if (cyc != 256) begin errors++; $display("FAIL clr_sweep_len: got %0d want 256", cyc); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL clr_done: got %0b want 1", init_done); end
        @(posedge clk); #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'h0) begin errors++; $display("FAIL clr_zeroed: got v=%0b d=%h want v=1 d=0", a_rvalid, a_rdata); end
        @(negedge clk); a_req = 1'b0;
    endtask

    task automatic test_async_rst();
        int cyc;
        bit seen_rvalid;
        @(negedge clk); a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 64'h77;
        @(negedge clk); a_we = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'h77) begin errors++; $display("FAIL pre_rst_rd: got v=%0b d=%h want v=1 d=77", a_rvalid, a_rdata); end
        @(negedge clk); a_we = 1'b1; a_addr = 8'hFF; a_wdata = 64'hABC;
        @(posedge clk); #1;
        checks++; if (io_write !== 1'b1 || io_data !== 64'hABC) begin errors++; $display("FAIL pre_rst_io: got %0b/%h want 1/abc", io_write, io_data); end
        @(negedge clk); a_we = 1'b0; a_addr = 8'h20;
        #2; rst = 1'b1; #1;
        checks++; if (a_gnt !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL arst_gnt_done: got %0b/%0b want 0/0", a_gnt, init_done); end
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== 64'h0 || b_rdata !== 64'h0) begin errors++; $display("FAIL arst_rd: got v=%0b a=%h b=%h want 0/0/0", a_rvalid, a_rdata, b_rdata); end
        checks++; if (io_write !== 1'b0 || io_data !== 64'h0 || conflict_cnt !== 16'h0) begin errors++; $display("FAIL arst_io_cnt: got %0b/%h/%0d want 0/0/0", io_write, io_data, conflict_cnt); end
        @(negedge clk); rst = 1'b0; a_req = 1'b0;
        cyc = 0; seen_rvalid = 1'b0;
        while (init_done !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1; cyc++;
            if (a_rvalid === 1'b1) seen_rvalid = 1'b1;
        end
        checks++; if (seen_rvalid) begin errors++; $display("FAIL arst_dropped: got rvalid after reset want none"); end
        checks++; if (cyc != 256) begin errors++; $display("FAIL arst_sweep_len: got %0d want 256", cyc); end
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = 8'h20;
        @(posedge clk); #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'h0) begin errors++; $display("FAIL arst_zeroed: got v=%0b d=%h want v=1 d=0", a_rvalid, a_rdata); end
        @(negedge clk); a_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_reads();
        test_write_read();
        test_contention();
        test_io();
        test_clr();
        test_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
